// File: rtl/reg_bank.sv
// reg_bank: general-purpose register file for the KGP-RISC datapath.
// Writes are steered by a one-hot WriteFlag vector from the address decoder;
// multi-hot vectors are rejected and latched into a sticky error flag.
// Two combinational read ports, plus a saturating count of committed writes.
// Optional feature macro: REG_BANK_BYPASS_EN (write-through read bypass).
module reg_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REGS-1:0]   WriteFlag,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [4:0]            ReadReg1,
    input  logic [4:0]            ReadReg2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic                  MultiHotErr,
    output logic [15:0]           WriteCount
);

    typedef enum logic {
        ERR_OK  = 1'b0,
        ERR_SET = 1'b1
    } err_state_e;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [15:0]           count_q;
    logic [15:0]           count_d;
    err_state_e            err_state_q;
    err_state_e            err_state_d;

    logic flag_zero;
    logic flag_onehot;
    logic wr_legal;
    logic wr_illegal;

    // Classify the write vector: clearing the lowest set bit leaves zero
    // only when exactly one bit was set.
    always_comb begin
        flag_zero   = (WriteFlag == '0);
        flag_onehot = !flag_zero && ((WriteFlag & (WriteFlag - NUM_REGS'(1))) == '0);
        wr_legal    = flag_onehot;
        wr_illegal  = !flag_zero && !flag_onehot;
    end

    // Next register contents: only a legal write touches the flagged entry.
    always_comb begin
        regs_d = regs_q;
        if (wr_legal) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (WriteFlag[i]) begin
                    regs_d[i] = WriteData;
                end
            end
        end
    end

    // Next write count: legal writes only, holding at all-ones.
    always_comb begin
        count_d = count_q;
        if (wr_legal && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Next error state: sticky once set; only reset returns it to OK.
    always_comb begin
        err_state_d = err_state_q;
        if (err_state_q == ERR_OK && wr_illegal) begin
            err_state_d = ERR_SET;
        end
    end

    // State update; reset wins over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            count_q     <= '0;
            err_state_q <= ERR_OK;
        end else begin
            regs_q      <= regs_d;
            count_q     <= count_d;
            err_state_q <= err_state_d;
        end
    end

    // Read one port; indices beyond the bank read as zero.
    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [4:0] idx);
        logic [DATA_WIDTH-1:0] val;
        val = '0;
        if (int'(idx) < NUM_REGS) begin
            val = regs_q[idx];
`ifdef REG_BANK_BYPASS_EN
            if (wr_legal && WriteFlag[idx]) begin
                val = WriteData;
            end
`endif
        end
`ifdef REG_BANK_BYPASS_EN
        if (rst) begin
            val = '0;
        end
`endif
        return val;
    endfunction

    // Combinational read ports and registered status outputs.
    always_comb begin
        ReadData1   = read_port(ReadReg1);
        ReadData2   = read_port(ReadReg2);
        MultiHotErr = (err_state_q == ERR_SET);
        WriteCount  = count_q;
    end

endmodule

// File: doc/reg_bank.md
# reg_bank

Register file for the KGP-RISC datapath that sits directly downstream of the write-address decoder and consumes its one-hot `WriteFlag` vector. It holds the architectural general-purpose registers and writes `WriteData` into the single register whose flag bit is set. It serves two combinational read ports to the decode/execute stage, rejects illegal multi-hot write vectors, and keeps a saturating count of committed writes for debug.

## Interface
- `DATA_WIDTH`, 32, width of each register and of the data ports
- `NUM_REGS`, 32, number of registers; equals the width of `WriteFlag`
- `clk`  input  1  single clock; all state updates on its rising edge
- `rst`  input  1  reset, synchronous and active-high
- `WriteFlag`  input  NUM_REGS  one-hot write enable per register from the decoder; all-zero means no write
- `WriteData`  input  DATA_WIDTH  data written to the flagged register
- `ReadReg1`  input  5  read port 1 register index
- `ReadReg2`  input  5  read port 2 register index
- `ReadData1`  output  DATA_WIDTH  contents of register `ReadReg1`
- `ReadData2`  output  DATA_WIDTH  contents of register `ReadReg2`
- `MultiHotErr`  output  1  sticky flag, set when `WriteFlag` had more than one bit set
- `WriteCount`  output  16  saturating count of committed writes

## Operation
- Storage: `NUM_REGS` registers of `DATA_WIDTH` bits. All registers are writable, including register 0. There is no hardwired zero.
- Flag classification, evaluated every cycle on `WriteFlag`:
  - zero: idle
  - exactly one bit set: legal write
  - two or more bits set: illegal
- Legal write: at the rising edge, register i (the set bit) loads `WriteData`. `WriteCount` increments by 1 and saturates at 16'hFFFF (no wrap).
- Illegal vector:
  - No register is modified.
  - `WriteCount` is unchanged.
  - `MultiHotErr` is set at that edge and stays 1 until `rst`.
- Reads are combinational: `ReadDataN` = reg[`ReadRegN`]. Both ports may address the same register.
- Reset (`rst`=1 at a rising edge):
  - every register is cleared to 0
  - `WriteCount` is cleared to 0
  - `MultiHotErr` is cleared to 0
  - reset has priority over any simultaneous write, legal or illegal
- Reset mid-operation: a write presented in the reset cycle is discarded. The first write accepted is the one presented in the first cycle with `rst`=0.
- Error-detect state: `MultiHotErr` is a two-state sticky machine. OK goes to ERR on an illegal vector. ERR goes back to OK only on `rst`. Legal writes continue normally while in ERR.

## Timing
- Write latency: data is visible on a read port in the cycle after the write edge (1 cycle).
- Read latency: 0 cycles (combinational from `ReadRegN` and register state).
- `MultiHotErr` asserts in the cycle after the offending vector.
- `WriteCount` updates in the cycle after the legal write.
- Same-cycle read of the register being written:
  - without bypass, returns the old value
  - with bypass, see Configuration
- Output values after reset: `ReadData1`/`ReadData2` = 0 for any index, `MultiHotErr` = 0, `WriteCount` = 0.

## Configuration
- Macro: `REG_BANK_BYPASS_EN`.
- Defined: write-through bypass. If a legal write targets register i in the current cycle and `ReadRegN` == i, then `ReadDataN` = `WriteData` combinationally in that cycle.
  - No bypass on illegal vectors.
  - No bypass while `rst`=1 (returns 0).
- Not defined: reads always return stored contents. The new value appears one cycle after the write.

## Test plan
- Reset then read all 32 indices on both ports -> every read = 0, `WriteCount`=0, `MultiHotErr`=0.
- `WriteFlag`=32'h0000_0020, `WriteData`=32'hDEAD_BEEF, then read `ReadReg1`=5 next cycle -> 32'hDEAD_BEEF. `WriteCount`=1. Register 4 and register 6 still read 0.
- `WriteFlag`=32'h0000_0006, `WriteData`=32'h1234 -> registers 1 and 2 unchanged, `MultiHotErr`=1 next cycle and stays 1. A following legal write to register 3 still commits; `WriteCount` counts only that write.
- Write 32'hA5A5 to register 7 while `ReadReg2`=7 in the same cycle:
  - without `REG_BANK_BYPASS_EN`: same-cycle `ReadData2` = old value, next cycle = 32'hA5A5
  - with the macro: same-cycle `ReadData2` = 32'hA5A5
- Assert `rst` in the same cycle as a legal write to register 9 = 32'hFFFF_FFFF -> register 9 reads 0 afterwards, `WriteCount`=0.
- Drive 65,540 consecutive legal writes -> `WriteCount` reaches 16'hFFFF and holds there (no wrap to 0).
